pwm_wave_sample_fetcher: RTL and testbench

- Avalon-MM read master that streams waveform samples out of the on-chip sample memory (32-bit words, 17-bit word address, single-cycle read latency) into the PWM generator.
- Reads a programmed window of words, optionally looping, and buffers them in a small FIFO.
- Releases one sample per sample-rate tick to the PWM stage.
- Sits between the on-chip memory slave and the PWM duty/compare logic.

---
 rtl/pwm_wave_pkg.sv | 13 +
 rtl/wave_sample_fifo.sv | 71 +++++++
 rtl/pwm_wave_sample_fetcher.sv | 213 +++++++++++++++++++++
 tb/tb_pwm_wave_sample_fetcher.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_wave_pkg.sv
// Shared types and constants for the PWM waveform sample fetcher.
package pwm_wave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned MEM_WORDS_DEFAULT = 100000;
  localparam logic [3:0]  BYTEENABLE_ALL    = 4'hF;

endpackage

// File: rtl/wave_sample_fifo.sv
// Small first-word-fall-through sample buffer with synchronous flush.
module wave_sample_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              empty_q;
  logic              full_q;
  logic              do_push;
  logic              do_pop;

  // A pop frees a slot in the same cycle, so push into a full FIFO is fine then.
  assign do_pop  = pop && !empty_q;
  assign do_push = push && (!full_q || do_pop);

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/pwm_wave_sample_fetcher.sv
// Avalon-MM read master streaming a programmed window of sample words
// through a small FIFO, releasing one sample per rate-divider tick.
module pwm_wave_sample_fetcher
  import pwm_wave_pkg::*;
#(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_WORDS  = MEM_WORDS_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cfg_start_addr,
  input  logic [ADDR_W-1:0] cfg_length,
  input  logic              cfg_loop,
  input  logic [DIV_W-1:0]  cfg_rate_div,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_strobe
);

  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W     = CNT_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [ADDR_W-1:0] win_addr_q, win_addr_d;
  logic [ADDR_W-1:0] win_len_q, win_len_d;
  logic              loop_q, loop_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              rd_pending_q, rd_pending_d;
  logic              busy_d, done_d, underrun_d, strobe_d, cs_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] smp_d;
  logic              tick_c, issue_ok_c, flush_c, pop_c;
  logic [OCC_W-1:0]  occupancy_c;
  logic [DATA_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;

  assign mem_write      = 1'b0;
  assign mem_byteenable = BYTEENABLE_ALL;
  assign mem_clken      = 1'b1;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  wave_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush_c),
    .push  (rd_pending_q),
    .pop   (pop_c),
    .din   (mem_readdata),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    remaining_d  = remaining_q;
    win_addr_d   = win_addr_q;
    win_len_d    = win_len_q;
    loop_d       = loop_q;
    div_d        = div_q;
    div_cnt_d    = div_cnt_q;
    rd_pending_d = mem_chipselect;
    cs_d         = 1'b0;
    addr_d       = mem_address;
    done_d       = 1'b0;
    underrun_d   = 1'b0;
    strobe_d     = 1'b0;
    smp_d        = smp_data;
    flush_c      = 1'b0;
    pop_c        = 1'b0;
    // Words already owed to the FIFO: buffered, on the bus now, and returning now.
    occupancy_c  = OCC_W'(fifo_count) + OCC_W'(mem_chipselect) + OCC_W'(rd_pending_q);
    issue_ok_c   = (state_q == RUN) && (remaining_q != '0) && !fifo_full &&
                   (occupancy_c < OCC_W'(FIFO_DEPTH));
    tick_c       = (state_q != IDLE) && (div_cnt_q == div_q);

    if (stop) begin
      state_d      = IDLE;
      flush_c      = 1'b1;
      rd_pending_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && (cfg_length != '0)) begin
            win_addr_d  = cfg_start_addr;
            win_len_d   = cfg_length;
            loop_d      = cfg_loop;
            div_d       = cfg_rate_div;
            div_cnt_d   = '0;
            flush_c     = 1'b1;
            cs_d        = 1'b1;
            addr_d      = cfg_start_addr;
            state_d     = RUN;
            rd_addr_d   = next_addr(cfg_start_addr);
            remaining_d = cfg_length - ADDR_W'(1);
            if (cfg_length == ADDR_W'(1)) begin
              if (cfg_loop) begin
                rd_addr_d   = cfg_start_addr;
                remaining_d = cfg_length;
              end else begin
                state_d = DRAIN;
              end
            end
          end
        end
        RUN, DRAIN: begin
          div_cnt_d = tick_c ? '0 : div_cnt_q + DIV_W'(1);
          if (issue_ok_c) begin
            cs_d        = 1'b1;
            addr_d      = rd_addr_q;
            rd_addr_d   = next_addr(rd_addr_q);
            remaining_d = remaining_q - ADDR_W'(1);
            // Last word of the window: wrap back with no gap or start draining.
            if (remaining_q == ADDR_W'(1)) begin
              if (loop_q) begin
                rd_addr_d   = win_addr_q;
                remaining_d = win_len_q;
              end else begin
                state_d = DRAIN;
              end
            end
          end
          if (tick_c) begin
            if (!fifo_empty) begin
              pop_c    = 1'b1;
              smp_d    = fifo_dout;
              strobe_d = 1'b1;
            end else if (state_q == RUN) begin
              underrun_d = 1'b1;
            end else if (!mem_chipselect && !rd_pending_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q      <= '0;
      remaining_q    <= '0;
      win_addr_q     <= '0;
      win_len_q      <= '0;
      loop_q         <= 1'b0;
      div_q          <= '0;
      div_cnt_q      <= '0;
      rd_pending_q   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      underrun       <= 1'b0;
      mem_chipselect <= 1'b0;
      mem_address    <= '0;
      smp_data       <= '0;
      smp_strobe     <= 1'b0;
    end else begin
      rd_addr_q      <= rd_addr_d;
      remaining_q    <= remaining_d;
      win_addr_q     <= win_addr_d;
      win_len_q      <= win_len_d;
      loop_q         <= loop_d;
      div_q          <= div_d;
      div_cnt_q      <= div_cnt_d;
      rd_pending_q   <= rd_pending_d;
      busy           <= busy_d;
      done           <= done_d;
      underrun       <= underrun_d;
      mem_chipselect <= cs_d;
      mem_address    <= addr_d;
      smp_data       <= smp_d;
      smp_strobe     <= strobe_d;
    end
  end

endmodule

// File: tb/tb_pwm_wave_sample_fetcher.sv
// Directed scoreboard bench for pwm_wave_sample_fetcher with a behavioural sample memory.
module tb_pwm_wave_sample_fetcher;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [16:0] cfg_start_addr;
  logic [16:0] cfg_length;
  logic        cfg_loop;
  logic [15:0] cfg_rate_div;
  logic        start;
  logic        stop;
  logic        busy, done, underrun;
  logic [16:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic [31:0] smp_data;
  logic        smp_strobe;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cs_cnt = 0, strb_cnt = 0, und_cnt = 0, done_cnt = 0;
  int cs_base = 0, strb_base = 0, und_base = 0, done_base = 0;
  bit loop_phase = 1'b0;
  logic [16:0] exp_addr[$];
  logic [31:0] exp_smp[$];
  int          strb_times[$];
  logic [31:0] last_exp = '0;
  logic [31:0] exp_v;
  bit          got;

  pwm_wave_sample_fetcher dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start_addr (cfg_start_addr),
    .cfg_length     (cfg_length),
    .cfg_loop       (cfg_loop),
    .cfg_rate_div   (cfg_rate_div),
    .start          (start),
    .stop           (stop),
    .busy           (busy),
    .done           (done),
    .underrun       (underrun),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .smp_data       (smp_data),
    .smp_strobe     (smp_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [16:0] a);
    case (a)
      17'd0:   return 32'h0000_000A;
      17'd1:   return 32'h0000_000B;
      17'd10:  return 32'd1;
      17'd11:  return 32'd2;
      17'd12:  return 32'd3;
      17'd13:  return 32'd4;
      default: return {15'h2A5A, a};
    endcase
  endfunction

  // Single-cycle-latency memory slave.
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) mem_readdata <= mem_word(mem_address);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic snapshot();
    cs_base   = cs_cnt;
    strb_base = strb_cnt;
    und_base  = und_cnt;
    done_base = done_cnt;
    strb_times.delete();
  endtask

  // Output monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (mem_chipselect) begin
      cs_cnt++;
      if (exp_addr.size() == 0) check("cs_unexpected", 64'(mem_chipselect), 64'd0);
      else check("mem_address", 64'(mem_address), 64'(exp_addr.pop_front()));
    end
    if (smp_strobe) begin
      strb_cnt++;
      strb_times.push_back(cyc);
      if (exp_smp.size() == 0) check("strobe_unexpected", 64'(smp_strobe), 64'd0);
      else begin
        exp_v = exp_smp.pop_front();
        check("smp_data", 64'(smp_data), 64'(exp_v));
        last_exp = exp_v;
      end
    end
    if (underrun) begin
      und_cnt++;
      check("underrun_hold", 64'(smp_data), 64'(last_exp));
      check("underrun_no_strobe", 64'(smp_strobe), 64'd0);
    end
    if (done) done_cnt++;
    if (loop_phase)
      check("loop_ahead", 64'(((cs_cnt - cs_base) - (strb_cnt - strb_base)) <= DEPTH), 64'd1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_start_addr = '0; cfg_length = '0; cfg_loop = 1'b0; cfg_rate_div = '0;
    step(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_cs", 64'(mem_chipselect), 64'd0);
    check("rst_strobe", 64'(smp_strobe), 64'd0);
    check("rst_addr", 64'(mem_address), 64'd0);
    check("rst_smp", 64'(smp_data), 64'd0);
    check("tie_write", 64'(mem_write), 64'd0);
    check("tie_be", 64'(mem_byteenable), 64'hF);
    check("tie_clken", 64'(mem_clken), 64'd1);
    reset = 1'b0;
    step(2);

    // Zero-length start is ignored.
    cfg_start_addr = 17'd10; cfg_length = 17'd0; cfg_rate_div = 16'd3;
    pulse_start();
    check("len0_busy", 64'(busy), 64'd0);
    step(2);
    check("len0_busy_later", 64'(busy), 64'd0);

    // Start together with stop: stop wins.
    cfg_length = 17'd4;
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", 64'(busy), 64'd0);
    check("startstop_cs", 64'(mem_chipselect), 64'd0);
    step(3);

    // One-shot window 10..13 at one sample every 4 cycles.
    snapshot();
    cfg_start_addr = 17'd10; cfg_length = 17'd4; cfg_loop = 1'b0; cfg_rate_div = 16'd3;
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(17'(10 + i));
      exp_smp.push_back(32'(i + 1));
    end
    pulse_start();
    check("oneshot_cs_first", 64'(mem_chipselect), 64'd1);
    check("oneshot_busy", 64'(busy), 64'd1);
    wait_done(80, got);
    check("oneshot_done_seen", 64'(got), 64'd1);
    check("oneshot_busy_fall", 64'(busy), 64'd0);
    step(1);
    check("oneshot_done_pulse", 64'(done), 64'd0);
    check("oneshot_cs_count", 64'(cs_cnt - cs_base), 64'd4);
    check("oneshot_strobes", 64'(strb_cnt - strb_base), 64'd4);
    check("oneshot_done_count", 64'(done_cnt - done_base), 64'd1);
    check("oneshot_underruns", 64'(und_cnt - und_base), 64'd0);
    for (int i = 1; i < strb_times.size(); i++)
      check("oneshot_interval", 64'(strb_times[i] - strb_times[i-1]), 64'd4);
    step(2);

    // Endless two-word loop at full rate; two startup ticks precede the first data.
    snapshot();
    cfg_start_addr = 17'd0; cfg_length = 17'd2; cfg_loop = 1'b1; cfg_rate_div = 16'd0;
    for (int i = 0; i < 80; i++) begin
      exp_addr.push_back(17'(i % 2));
      exp_smp.push_back((i % 2 == 0) ? 32'hA : 32'hB);
    end
    loop_phase = 1'b1;
    pulse_start();
    step(50);
    check("loop_busy", 64'(busy), 64'd1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    loop_phase = 1'b0;
    exp_addr.delete();
    exp_smp.delete();
    check("loop_stop_busy", 64'(busy), 64'd0);
    check("loop_stop_cs", 64'(mem_chipselect), 64'd0);
    check("loop_strobes_min", 64'((strb_cnt - strb_base) >= 45), 64'd1);
    check("loop_underruns", 64'(und_cnt - und_base), 64'd2);
    check("loop_no_done", 64'(done_cnt - done_base), 64'd0);
    step(3);

    // Address wraps at the end of memory.
    snapshot();
    cfg_start_addr = 17'd99998; cfg_length = 17'd4; cfg_loop = 1'b0; cfg_rate_div = 16'd0;
    exp_addr.push_back(17'd99998); exp_addr.push_back(17'd99999);
    exp_addr.push_back(17'd0);     exp_addr.push_back(17'd1);
    exp_smp.push_back(mem_word(17'd99998)); exp_smp.push_back(mem_word(17'd99999));
    exp_smp.push_back(mem_word(17'd0));     exp_smp.push_back(mem_word(17'd1));
    pulse_start();
    wait_done(40, got);
    check("wrap_done_seen", 64'(got), 64'd1);
    step(1);
    check("wrap_addr_left", 64'(exp_addr.size()), 64'd0);
    check("wrap_smp_left", 64'(exp_smp.size()), 64'd0);
    check("wrap_underruns", 64'(und_cnt - und_base), 64'd2);
    step(2);

    // Stop right after the first requests; their data must never surface.
    snapshot();
    cfg_start_addr = 17'd20; cfg_length = 17'd8; cfg_loop = 1'b0; cfg_rate_div = 16'd5;
    exp_addr.push_back(17'd20); exp_addr.push_back(17'd21);
    pulse_start();
    check("stop_cs_seen", 64'(mem_chipselect), 64'd1);
    step(1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("stop_busy", 64'(busy), 64'd0);
    check("stop_cs", 64'(mem_chipselect), 64'd0);
    check("stop_smp_hold", 64'(smp_data), 64'(last_exp));
    step(10);
    check("stop_no_done", 64'(done_cnt - done_base), 64'd0);
    check("stop_no_strobe", 64'(strb_cnt - strb_base), 64'd0);
    check("stop_addr_left", 64'(exp_addr.size()), 64'd0);
    check("stop_smp_after", 64'(smp_data), 64'(last_exp));

    // Clean restart from a new window.
    snapshot();
    cfg_start_addr = 17'd30; cfg_length = 17'd2; cfg_rate_div = 16'd1;
    exp_addr.push_back(17'd30); exp_addr.push_back(17'd31);
    exp_smp.push_back(mem_word(17'd30)); exp_smp.push_back(mem_word(17'd31));
    pulse_start();
    wait_done(40, got);
    check("restart_done_seen", 64'(got), 64'd1);
    step(1);
    check("restart_strobes", 64'(strb_cnt - strb_base), 64'd2);
    check("restart_underruns", 64'(und_cnt - und_base), 64'd0);
    step(2);

    // Reset in the middle of a run.
    snapshot();
    cfg_start_addr = 17'd40; cfg_length = 17'd8; cfg_rate_div = 16'd2;
    for (int i = 0; i < 8; i++) begin
      exp_addr.push_back(17'(40 + i));
      exp_smp.push_back(mem_word(17'(40 + i)));
    end
    pulse_start();
    step(8);
    check("midrst_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    step(1);
    exp_addr.delete();
    exp_smp.delete();
    last_exp = '0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_underrun", 64'(underrun), 64'd0);
    check("midrst_cs", 64'(mem_chipselect), 64'd0);
    check("midrst_strobe", 64'(smp_strobe), 64'd0);
    check("midrst_addr", 64'(mem_address), 64'd0);
    check("midrst_smp", 64'(smp_data), 64'd0);
    reset = 1'b0;
    step(5);
    check("midrst_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
